// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Holds the arbiter state encoding, the default burst limit and a wrap-around increment.
// Pure declarations only; no logic and no latency of its own.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int ARB_MAX_BURST = 4;

    // Wrap-around increment that is correct for non-power-of-two n.
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// First-one search over a request vector, starting at a rotating pointer, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is used.
//
// Ports:
//   i_active  - request vector, one bit per requester
//   i_start   - index searched first; the search proceeds upward with wrap
//   o_onehot  - one-hot pick, all zero when i_active is zero
//   o_idx     - binary index of the pick (0 when nothing is picked)
module rr_priority_pick #(
    parameter int NUM_FIFOS = 4,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
    input  logic [NUM_FIFOS-1:0] i_active,
    input  logic [TAGWIDTH-1:0]  i_start,
    output logic [NUM_FIFOS-1:0] o_onehot,
    output logic [TAGWIDTH-1:0]  o_idx
);

    // One extra bit so start + offset can exceed NUM_FIFOS-1 before wrapping.
    localparam int SW = TAGWIDTH + 1;

    logic [NUM_FIFOS-1:0] w_rot;
    logic                 w_found;
    logic [SW-1:0]        w_off;
    logic [SW-1:0]        w_sum;

    // Doubling the vector makes a right shift behave as a rotate; bit k of
    // w_rot is requester (start + k) mod NUM_FIFOS.
    assign w_rot = NUM_FIFOS'({i_active, i_active} >> i_start);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        // Descending scan so the lowest set offset is the one that sticks.
        for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = SW'(k);
            end
        end
        w_sum = {1'b0, i_start} + w_off;
        if (w_sum >= SW'(NUM_FIFOS)) begin
            w_sum = w_sum - SW'(NUM_FIFOS);
        end
        o_idx    = w_sum[TAGWIDTH-1:0];
        o_onehot = '0;
        if (w_found) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin pop arbiter: one non-empty requesting FIFO per cycle, owner may hold up to MAX_BURST pops.
// Latency: grant is combinational from registered priority state, so the pop happens in the request cycle.
// Backpressure: empty FIFOs are never granted; an owner that stops requesting loses the grant the same cycle.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (grant is forced off while in reset)
//   reqs       - per-FIFO request
//   empty      - per-FIFO empty flag
//   gnt        - one-hot grant (all zero when nothing granted), drives FIFO pops
//   gnt_vld    - any grant this cycle
//   gnt_idx    - index of the granted FIFO; holds the last owner when nothing is granted
//   burst_cnt  - consecutive grants to the current owner including this cycle's, 0 when idle
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_FIFOS = 4,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
    parameter int MAX_BURST = ARB_MAX_BURST,
    parameter int CNTWIDTH  = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_FIFOS-1:0] reqs,
    input  logic [NUM_FIFOS-1:0] empty,
    output logic [NUM_FIFOS-1:0] gnt,
    output logic                 gnt_vld,
    output logic [TAGWIDTH-1:0]  gnt_idx,
    output logic [CNTWIDTH-1:0]  burst_cnt
);

    logic [TAGWIDTH-1:0]  r_owner;
    logic [CNTWIDTH-1:0]  r_cnt;
    arb_state_t           r_st;

    logic [NUM_FIFOS-1:0] w_active;
    logic [TAGWIDTH-1:0]  w_ptr;
    logic [NUM_FIFOS-1:0] w_pick_onehot;
    logic [TAGWIDTH-1:0]  w_pick_idx;
    logic                 w_hold;
    logic [NUM_FIFOS-1:0] w_hold_onehot;

    // Gating with rst_n makes the grant drop asynchronously when reset asserts.
    assign w_active = reqs & ~empty & {NUM_FIFOS{rst_n}};

    // The owner is searched last, so after exhaustion it is re-picked only
    // when it is the sole active requester.
    assign w_ptr = TAGWIDTH'(next_idx(int'(r_owner), NUM_FIFOS));

    rr_priority_pick #(
        .NUM_FIFOS (NUM_FIFOS),
        .TAGWIDTH  (TAGWIDTH)
    ) u_pick (
        .i_active (w_active),
        .i_start  (w_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx)
    );

    assign w_hold = (r_st == BURST) && w_active[r_owner] && (r_cnt < CNTWIDTH'(MAX_BURST));

    always_comb begin
        w_hold_onehot          = '0;
        w_hold_onehot[r_owner] = 1'b1;
    end

    assign gnt       = w_hold ? w_hold_onehot : w_pick_onehot;
    assign gnt_vld   = |gnt;
    assign gnt_idx   = w_hold ? r_owner : (gnt_vld ? w_pick_idx : r_owner);
    assign burst_cnt = w_hold ? (r_cnt + CNTWIDTH'(1)) : (gnt_vld ? CNTWIDTH'(1) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= TAGWIDTH'(NUM_FIFOS - 1);
            r_cnt   <= '0;
            r_st    <= IDLE;
        end else if (gnt_vld) begin
            if (w_hold) begin
                r_cnt <= r_cnt + CNTWIDTH'(1);
            end else begin
                r_owner <= w_pick_idx;
                r_cnt   <= CNTWIDTH'(1);
            end
            r_st <= BURST;
        end else begin
            // Owner is kept so priority resumes where it left off.
            r_st  <= IDLE;
            r_cnt <= '0;
        end
    end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Concrete arbiter that replaces the abstract arbiter in the arbitrated FIFO top.
- Grants pop permission to exactly one non-empty, requesting FIFO per cycle.
- Uses rotating round-robin priority with a bounded burst: the current owner may keep the grant for up to MAX_BURST consecutive pops before priority is forced to rotate.
- The grant is combinational from current state and inputs, so the pop happens in the same cycle. Priority and burst state are registered.

Parameters:
- NUM_FIFOS, 4, number of requesters/FIFOs; any value ≥ 2, need not be a power of two.
- TAGWIDTH, $clog2(NUM_FIFOS), width of the grant index.
- MAX_BURST, 4, maximum consecutive grants to one owner; ≥ 1. A value of 1 gives pure round-robin.
- CNTWIDTH, $clog2(MAX_BURST+1), width of the burst counter.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- reqs, input, NUM_FIFOS, per-FIFO request.
- empty, input, NUM_FIFOS, per-FIFO empty flag.
- gnt, output, NUM_FIFOS, one-hot grant (all zero when nothing is granted); drives the FIFO pops and the one-hot mux.
- gnt_vld, output, 1, equals |gnt.
- gnt_idx, output, TAGWIDTH, binary index of the granted FIFO; holds the last owner when gnt_vld=0.
- burst_cnt, output, CNTWIDTH, number of consecutive grants the current owner has received, including this cycle's if granted.

Behaviour:
- active = reqs & ~empty. A request from an empty FIFO is never granted.
- State registers:
  - owner [TAGWIDTH]
  - cnt [CNTWIDTH]
  - st ∈ {IDLE, BURST}
- Reset values (async on rst_n low):
  - owner = NUM_FIFOS-1, so the first search starts at index 0.
  - cnt = 0, st = IDLE.
  - gnt forced to 0, gnt_vld = 0, gnt_idx = NUM_FIFOS-1, burst_cnt = 0.
- Grant selection (combinational):
  - If active == 0: gnt = 0.
  - Else if st == BURST, active[owner] = 1 and cnt < MAX_BURST: grant owner (hold).
  - Else: grant the first set bit of active, searching upward from ptr = (owner+1) with wrap. The index after NUM_FIFOS-1 is 0, and ptr wraps explicitly for non-power-of-two NUM_FIFOS.
  - The owner is searched last, so it is re-granted after burst exhaustion only if it is the sole active requester (work-conserving).
- Register update at posedge:
  - If gnt_vld and the grant was a hold: cnt <= cnt+1, st <= BURST.
  - If gnt_vld and it is a new selection (including re-selecting owner after exhaustion): owner <= granted idx, cnt <= 1, st <= BURST.
  - If !gnt_vld: st <= IDLE, cnt <= 0, owner unchanged, so priority continues from where it left off.
- burst_cnt output:
  - When granted: the post-grant count (cnt+1 for a hold, 1 for a new selection).
  - Otherwise: 0.
- Owner drops its request or goes empty mid-burst: the burst ends immediately and a new selection happens the same cycle.
- Invariants, which the verification engineer asserts:
  - gnt is one-hot or zero.
  - (gnt & ~active) == 0.
  - active != 0 implies gnt_vld.
  - cnt ≤ MAX_BURST.
  - Fairness: a continuously active requester is granted within (NUM_FIFOS-1)*MAX_BURST+1 cycles.
- Reset asserted mid-burst: gnt drops to 0 asynchronously. After release, arbitration restarts from index 0.

Decomposition:
- Shared package arb_pkg holds:
  - typedef arb_state_t {IDLE, BURST}
  - a function next_idx(idx, n) for wrap-around increment
  - the default MAX_BURST constant
- One sub-module, rr_priority_pick: combinational, takes the active vector and start pointer, returns one-hot and index. It implements the double-width rotate and first-one search, and is reusable by round_robin_selector-style blocks.

Test Plan (NUM_FIFOS=4, MAX_BURST=2 unless noted):
- Reset released, reqs=4'b1111, empty=0 held → gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001; burst_cnt 1,2,1,2,…
- reqs=4'b0100 only, empty=0 → gnt=0100 every cycle; burst_cnt 1,2,1,2 (re-selection after exhaustion).
- reqs=4'b1111, empty=4'b1111 → gnt=0000, gnt_vld=0, burst_cnt=0, st stays IDLE. Then empty=4'b1011 → gnt=0100 in the same cycle.
- reqs=4'b0011 gives gnt=0001 at cycle 0. At cycle 1 reqs=4'b0010 → gnt=0010, burst_cnt=1; owner change without waiting for exhaustion.
- Mid-burst (owner=2, cnt=1), pull rst_n low between clock edges → gnt=0000 immediately. After release with reqs=4'b1100 → first gnt=0100, burst_cnt=1.
- MAX_BURST=1, reqs=4'b1111 → gnt 0001,0010,0100,1000,0001. With NUM_FIFOS=3 and reqs=3'b111 → 001,010,100,001 (wrap check).
